spi_mem_ctrl: RTL and testbench
===============================

SPI_MEM_CTRL -- requirements
Module: spi_mem_ctrl

Interface
REQ-001 SHALL have parameter SCLK_HALF, default 1, system clocks per SCLK half-period (legal 1..15).
REQ-002 SHALL have clk_in  input  1  the only clock; all logic on rising edge.
REQ-003 SHALL have reset_in  input  1  asynchronous, active-high reset.
REQ-004 SHALL have if_req_in  input  1  instruction fetch request, flash read only; held until ack.
REQ-005 SHALL have if_addr_in  input  24  fetch byte address.
REQ-006 SHALL have if_ack_out / if_rdata_out  output  1 / 8  one-cycle completion pulse / read byte, valid with ack.
REQ-007 SHALL have d_req_in, d_we_in, d_psram_sel_in  input  1 each  data request, write enable, target (1=PSRAM, 0=flash).
REQ-008 SHALL have d_addr_in  input  24  and d_wdata_in  input  8  for data access.
REQ-009 SHALL have d_ack_out, d_err_out  output  1 each, and d_rdata_out  output  8.
REQ-010 SHALL have sclk_out, mosi_out, flash_cs_out, psram_cs_out  output  1 each, and miso_in  input  1; CS active-low.
REQ-011 SHALL have busy_out  output  1, high whenever state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, SHIFT, DONE.
REQ-013 In IDLE SHALL grant a request: if only one pending, that one; if both, the port not served last (two-way round-robin, data wins the first tie after reset).
REQ-014 SHALL latch address, we, target, wdata at grant; later request-input changes SHALL be ignored until ack.
REQ-015 Data write with d_psram_sel_in=0 SHALL NOT start SPI; SHALL go to DONE and pulse d_ack_out and d_err_out together on the next cycle, d_rdata_out=0.
REQ-016 Otherwise cycle after grant: selected CS low, state SHIFT, 40 bits sent MSB first: command (0x03 read, 0x02 write), address[23:0], data byte (wdata or 0x00 on read).
REQ-017 SPI mode 0: sclk_out low SCLK_HALF cycles, then high SCLK_HALF cycles per bit; mosi_out changes only while sclk low; miso_in sampled on the clk edge driving sclk_out high.
REQ-018 Read data SHALL be the 8 bits sampled during bits 32..39.
REQ-019 After bit 39 high phase, SHALL enter DONE: CS high, sclk low, mosi low, ack pulse one cycle with rdata; next cycle IDLE.
REQ-020 With SCLK_HALF=1 the grant-to-ack latency SHALL be exactly 81 cycles (CS low 80 cycles); CS high at least 2 cycles between transactions.
REQ-021 Never both CS low; the unselected CS SHALL stay high throughout.
REQ-022 Request dropped mid-transaction: transaction still completes and ack still pulses.
REQ-023 d_rdata_out/if_rdata_out SHALL hold last value between acks; d_err_out low except REQ-015.

Reset
REQ-024 On reset_in high, immediately: state IDLE, flash_cs_out=psram_cs_out=1, sclk_out=0, mosi_out=0, acks=0, d_err_out=0, busy_out=0, rdata=0x00, round-robin pointer to data.
REQ-025 Reset mid-SHIFT SHALL abort without ack; first grant after release restarts from command bit 7.

Structure
REQ-026 Package spi_mem_pkg SHALL hold state enum, CMD_READ=0x03, CMD_WRITE=0x02, ADDR_W=24, FRAME_BITS=40.
REQ-027 Sub-module spi_shift_unit SHALL own the 40-bit shift register, bit counter, half-period divider and sclk/mosi/miso sampling; spi_mem_ctrl holds arbitration and FSM.

Verification
REQ-028 Fetch 0x000100, MISO model returns 0xA5 -> flash CS low 80 cycles, MOSI 0x03_000100_00, if_ack at grant+81, if_rdata_out=0xA5.
REQ-029 PSRAM write 0x123456 data 0x3C -> psram CS only, MOSI 0x02_123456_3C, d_ack pulse, d_err_out=0.
REQ-030 Fetch and data requested same cycle from reset, both held -> data served first, fetch next, exactly one ack each, CS high >=2 cycles between.
REQ-031 Flash write request -> no CS activity, d_ack_out and d_err_out high same single cycle after grant.
REQ-032 reset_in asserted at bit 20 of a PSRAM read -> both CS high, sclk low same cycle, no ack; new request after release completes normally.
REQ-033 SCLK_HALF=3 fetch -> sclk period 6 cycles, CS low 240 cycles, correct data.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI memory controller: frame layout,
// command opcodes and FSM state encoding.
package spi_mem_pkg;

  localparam int         ADDR_W     = 24;
  localparam int         FRAME_BITS = 40;
  localparam int         CNT_W      = $clog2(FRAME_BITS);
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h02;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // Command, address, then data byte (zero filler on reads), sent MSB first.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic              we,
    input logic [ADDR_W-1:0] addr,
    input logic [7:0]        wdata
  );
    return {(we ? CMD_WRITE : CMD_READ), addr, (we ? wdata : 8'h00)};
  endfunction

endpackage

// File: rtl/spi_mem_ctrl_if.sv
// Request/response ports of the fetch and data requesters plus the SPI pins.
// The controller uses the slave view; the requester/board side uses master.
interface spi_mem_ctrl_if
  import spi_mem_pkg::*;
();

  logic              if_req_in;
  logic [ADDR_W-1:0] if_addr_in;
  logic              if_ack_out;
  logic [7:0]        if_rdata_out;

  logic              d_req_in;
  logic              d_we_in;
  logic              d_psram_sel_in;
  logic [ADDR_W-1:0] d_addr_in;
  logic [7:0]        d_wdata_in;
  logic              d_ack_out;
  logic              d_err_out;
  logic [7:0]        d_rdata_out;

  logic              sclk_out;
  logic              mosi_out;
  logic              flash_cs_out;
  logic              psram_cs_out;
  logic              miso_in;
  logic              busy_out;

  modport slave (
    input  if_req_in, if_addr_in,
    input  d_req_in, d_we_in, d_psram_sel_in, d_addr_in, d_wdata_in,
    input  miso_in,
    output if_ack_out, if_rdata_out,
    output d_ack_out, d_err_out, d_rdata_out,
    output sclk_out, mosi_out, flash_cs_out, psram_cs_out, busy_out
  );

  modport master (
    output if_req_in, if_addr_in,
    output d_req_in, d_we_in, d_psram_sel_in, d_addr_in, d_wdata_in,
    output miso_in,
    input  if_ack_out, if_rdata_out,
    input  d_ack_out, d_err_out, d_rdata_out,
    input  sclk_out, mosi_out, flash_cs_out, psram_cs_out, busy_out
  );

endinterface

// File: rtl/spi_shift_unit.sv
// Mode-0 SPI frame engine: shifts a 40-bit frame out MSB first, divides clk
// into SCLK half-periods and captures MISO on each SCLK rising edge.
module spi_shift_unit
  import spi_mem_pkg::*;
#(
  parameter int SCLK_HALF = 1
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  i_start,
  input  logic [FRAME_BITS-1:0] i_frame,
  input  logic                  i_miso,
  output logic                  o_sclk,
  output logic                  o_mosi,
  output logic                  o_done,
  output logic [7:0]            o_rdata
);

  localparam logic [3:0]       DIV_LAST = 4'(SCLK_HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] r_sr;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [3:0]            r_div;
  logic                  r_active;
  logic                  r_sclk;
  logic [7:0]            r_rx;
  logic                  w_phase_end;
  logic                  w_last_bit;

  assign w_phase_end = (r_div == DIV_LAST);
  assign w_last_bit  = (r_bit_cnt == BIT_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
      r_div     <= '0;
      r_active  <= 1'b0;
      r_sclk    <= 1'b0;
      r_rx      <= '0;
    end else if (i_start) begin
      r_sr      <= i_frame;
      r_bit_cnt <= '0;
      r_div     <= '0;
      r_active  <= 1'b1;
      r_sclk    <= 1'b0;
    end else if (r_active) begin
      if (!w_phase_end) begin
        r_div <= r_div + 4'd1;
      end else begin
        r_div <= '0;
        if (!r_sclk) begin
          r_sclk <= 1'b1;
          r_rx   <= {r_rx[6:0], i_miso};
        end else begin
          r_sclk <= 1'b0;
          if (w_last_bit) begin
            r_active <= 1'b0;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            r_sr      <= {r_sr[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
    end
  end

  // The shift register only moves on SCLK falling edges, so MOSI is stable
  // through every high phase and drops to 0 the moment the frame ends.
  assign o_mosi  = r_active & r_sr[FRAME_BITS-1];
  assign o_sclk  = r_sclk;
  assign o_done  = r_active & r_sclk & w_phase_end & w_last_bit;
  assign o_rdata = r_rx;

endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI flash/PSRAM controller: round-robin arbitration between instruction
// fetch and data ports, transaction FSM and response registers.
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int SCLK_HALF = 1
) (
  input  logic           clk_in,
  input  logic           reset_in,
  spi_mem_ctrl_if.slave  bus
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_prio_data;
  logic                  r_port_data;
  logic                  r_psram;
  logic                  r_err;
  logic [7:0]            r_if_rdata;
  logic [7:0]            r_d_rdata;
  logic                  w_pick_data;
  logic                  w_flash_wr;
  logic                  w_grant;
  logic                  w_start;
  logic                  w_done;
  logic [FRAME_BITS-1:0] w_frame;
  logic [7:0]            w_rx;

  // Data wins when it is the only requester or when it holds the tie priority.
  assign w_pick_data = bus.d_req_in & (~bus.if_req_in | r_prio_data);
  assign w_flash_wr  = w_pick_data & bus.d_we_in & ~bus.d_psram_sel_in;
  assign w_frame     = w_pick_data
                     ? build_frame(bus.d_we_in, bus.d_addr_in, bus.d_wdata_in)
                     : build_frame(1'b0, bus.if_addr_in, 8'h00);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt      = r_state;
    w_grant          = 1'b0;
    w_start          = 1'b0;
    bus.busy_out     = 1'b1;
    bus.if_ack_out   = 1'b0;
    bus.d_ack_out    = 1'b0;
    bus.d_err_out    = 1'b0;
    bus.flash_cs_out = 1'b1;
    bus.psram_cs_out = 1'b1;
    case (r_state)
      ST_IDLE: begin
        bus.busy_out = 1'b0;
        if (bus.if_req_in || bus.d_req_in) begin
          w_grant     = 1'b1;
          w_start     = ~w_flash_wr;
          w_state_nxt = w_flash_wr ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bus.flash_cs_out = r_psram;
        bus.psram_cs_out = ~r_psram;
        if (w_done) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        bus.if_ack_out = ~r_port_data;
        bus.d_ack_out  = r_port_data;
        bus.d_err_out  = r_err;
        w_state_nxt    = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_prio_data <= 1'b1;
      r_port_data <= 1'b0;
      r_psram     <= 1'b0;
      r_err       <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      if (w_grant) begin
        r_port_data <= w_pick_data;
        r_psram     <= w_pick_data & bus.d_psram_sel_in;
        r_err       <= w_flash_wr;
        r_prio_data <= ~w_pick_data;
        if (w_flash_wr) r_d_rdata <= '0;
      end
      if (w_done) begin
        if (r_port_data) r_d_rdata  <= w_rx;
        else             r_if_rdata <= w_rx;
      end
    end
  end

  assign bus.if_rdata_out = r_if_rdata;
  assign bus.d_rdata_out  = r_d_rdata;

  spi_shift_unit #(
    .SCLK_HALF (SCLK_HALF)
  ) u_shift (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .i_start  (w_start),
    .i_frame  (w_frame),
    .i_miso   (bus.miso_in),
    .o_sclk   (bus.sclk_out),
    .o_mosi   (bus.mosi_out),
    .o_done   (w_done),
    .o_rdata  (w_rx)
  );

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl: one instance at SCLK_HALF=1, one at 3,
// each with a negedge monitor that counts CS/ack activity and plays the MISO slave.
module tb_spi_mem_ctrl;
  import spi_mem_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_mem_ctrl_if b1 ();
  spi_mem_ctrl_if b3 ();

  spi_mem_ctrl #(.SCLK_HALF(1)) u_dut1 (.clk_in(clk), .reset_in(reset), .bus(b1));
  spi_mem_ctrl #(.SCLK_HALF(3)) u_dut3 (.clk_in(clk), .reset_in(reset), .bus(b3));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-instance monitor state, index 0 = SCLK_HALF 1, index 1 = SCLK_HALF 3.
  int          flash_low[2], psram_low[2], if_acks[2], d_acks[2], d_errs[2], err_ack[2];
  int          if_ack_cyc[2], d_ack_cyc[2], hi_run[2], last_gap[2];
  int          sclk_period[2], last_rise[2], miso_idx[2];
  int          both_low_total = 0;
  logic        had_low[2], prev_sclk[2], prev_cs_low[2];
  logic [39:0] cap[2];
  logic [7:0]  miso_byte[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    for (int k = 0; k < 2; k++) begin
      flash_low[k] = 0;  psram_low[k] = 0;  if_acks[k] = 0;  d_acks[k] = 0;
      d_errs[k] = 0;     err_ack[k] = 0;    if_ack_cyc[k] = 0; d_ack_cyc[k] = 0;
      hi_run[k] = 0;     last_gap[k] = 0;   sclk_period[k] = 0; last_rise[k] = -1;
      miso_idx[k] = 0;   had_low[k] = 1'b0; cap[k] = '0;
    end
  endtask

  task automatic mon_step(input int k, input logic fcs, pcs, sclk, mosi, ifack, dack, derr,
                          output logic miso);
    logic cs_low;
    cs_low = !fcs || !pcs;
    if (!fcs) flash_low[k]++;
    if (!pcs) psram_low[k]++;
    if (!fcs && !pcs) both_low_total++;
    if (cs_low && !prev_cs_low[k]) begin
      if (had_low[k]) last_gap[k] = hi_run[k];
      had_low[k]  = 1'b1;
      cap[k]      = '0;
      miso_idx[k] = 0;
    end
    if (cs_low) hi_run[k] = 0;
    else        hi_run[k]++;
    if (cs_low && sclk && !prev_sclk[k]) begin
      cap[k] = {cap[k][38:0], mosi};
      if (last_rise[k] >= 0) sclk_period[k] = cyc - last_rise[k];
      last_rise[k] = cyc;
    end
    if (cs_low && !sclk && prev_sclk[k]) miso_idx[k]++;
    if (ifack) begin if_acks[k]++; if_ack_cyc[k] = cyc; end
    if (dack)  begin d_acks[k]++;  d_ack_cyc[k]  = cyc; if (derr) err_ack[k]++; end
    if (derr)  d_errs[k]++;
    prev_sclk[k]   = sclk;
    prev_cs_low[k] = cs_low;
    miso = (miso_idx[k] >= 32 && miso_idx[k] <= 39) ? miso_byte[k][39 - miso_idx[k]] : 1'b0;
  endtask

  always @(negedge clk) begin
    logic m;
    mon_step(0, b1.flash_cs_out, b1.psram_cs_out, b1.sclk_out, b1.mosi_out,
             b1.if_ack_out, b1.d_ack_out, b1.d_err_out, m);
    b1.miso_in = m;
  end

  always @(negedge clk) begin
    logic m;
    mon_step(1, b3.flash_cs_out, b3.psram_cs_out, b3.sclk_out, b3.mosi_out,
             b3.if_ack_out, b3.d_ack_out, b3.d_err_out, m);
    b3.miso_in = m;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int k, input bit data_port, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      tick();
      ok = data_port ? (d_acks[k] != 0) : (if_acks[k] != 0);
    end
  endtask

  task automatic drive_d(input logic we, input logic sel, input logic [23:0] a, input logic [7:0] wd);
    b1.d_req_in = 1'b1; b1.d_we_in = we; b1.d_psram_sel_in = sel;
    b1.d_addr_in = a;   b1.d_wdata_in = wd;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int req_cyc;
    for (int k = 0; k < 2; k++) begin
      prev_sclk[k] = 1'b0; prev_cs_low[k] = 1'b0; miso_byte[k] = 8'h00;
    end
    b1.if_req_in = 0; b1.if_addr_in = '0; b1.d_req_in = 0; b1.d_we_in = 0;
    b1.d_psram_sel_in = 0; b1.d_addr_in = '0; b1.d_wdata_in = '0; b1.miso_in = 0;
    b3.if_req_in = 0; b3.if_addr_in = '0; b3.d_req_in = 0; b3.d_we_in = 0;
    b3.d_psram_sel_in = 0; b3.d_addr_in = '0; b3.d_wdata_in = '0; b3.miso_in = 0;
    clear_mon();

    // Reset state
    #2;
    check("rst_flash_cs", b1.flash_cs_out, 1);
    check("rst_psram_cs", b1.psram_cs_out, 1);
    check("rst_sclk",     b1.sclk_out, 0);
    check("rst_mosi",     b1.mosi_out, 0);
    check("rst_busy",     b1.busy_out, 0);
    check("rst_acks",     {b1.if_ack_out, b1.d_ack_out, b1.d_err_out}, 3'b000);
    check("rst_rdata",    {b1.if_rdata_out, b1.d_rdata_out}, 16'h0000);
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    // Fetch and data requested together straight out of reset: data first
    clear_mon();
    miso_byte[0] = 8'h5A;
    drive_d(1'b0, 1'b1, 24'h00ABCD, 8'h00);
    b1.if_req_in = 1'b1; b1.if_addr_in = 24'h000200;
    req_cyc = cyc;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      if (d_acks[0] != 0)  b1.d_req_in  = 1'b0;
      if (if_acks[0] != 0) b1.if_req_in = 1'b0;
      ok = (d_acks[0] != 0) && (if_acks[0] != 0);
    end
    check("tie_both_acked",  ok, 1);
    check("tie_data_lat",    d_ack_cyc[0] - req_cyc, 81);
    check("tie_fetch_lat",   if_ack_cyc[0] - req_cyc, 163);
    repeat (3) tick();
    check("tie_d_ack_once",  d_acks[0], 1);
    check("tie_if_ack_once", if_acks[0], 1);
    check("tie_cs_gap_ge2",  last_gap[0] >= 2, 1);
    check("tie_fetch_mosi",  cap[0], 40'h03_000200_00);
    check("tie_d_rdata",     b1.d_rdata_out, 8'h5A);

    // Instruction fetch from flash
    clear_mon();
    miso_byte[0] = 8'hA5;
    b1.if_req_in = 1'b1; b1.if_addr_in = 24'h000100;
    req_cyc = cyc;
    repeat (5) tick();
    check("fetch_busy", b1.busy_out, 1);
    b1.if_addr_in = 24'hFFFFFF;
    wait_ack(0, 1'b0, 200, ok);
    b1.if_req_in = 1'b0;
    check("fetch_ack_seen",  ok, 1);
    check("fetch_latency",   if_ack_cyc[0] - req_cyc, 81);
    check("fetch_flash_low", flash_low[0], 80);
    check("fetch_psram_low", psram_low[0], 0);
    check("fetch_mosi",      cap[0], 40'h03_000100_00);
    check("fetch_sclk_per",  sclk_period[0], 2);
    check("fetch_rdata",     b1.if_rdata_out, 8'hA5);
    check("fetch_no_d_ack",  d_acks[0], 0);
    tick();
    check("fetch_idle_busy", b1.busy_out, 0);
    check("fetch_rdata_hold", b1.if_rdata_out, 8'hA5);

    // PSRAM write
    clear_mon();
    drive_d(1'b1, 1'b1, 24'h123456, 8'h3C);
    req_cyc = cyc;
    wait_ack(0, 1'b1, 200, ok);
    b1.d_req_in = 1'b0;
    check("pwr_ack_seen",  ok, 1);
    check("pwr_latency",   d_ack_cyc[0] - req_cyc, 81);
    check("pwr_psram_low", psram_low[0], 80);
    check("pwr_flash_low", flash_low[0], 0);
    check("pwr_mosi",      cap[0], 40'h02_123456_3C);
    check("pwr_err",       d_errs[0], 0);
    check("pwr_ack_once",  d_acks[0], 1);

    // Flash write is refused without touching the bus
    clear_mon();
    drive_d(1'b1, 1'b0, 24'h000010, 8'h77);
    req_cyc = cyc;
    wait_ack(0, 1'b1, 20, ok);
    b1.d_req_in = 1'b0;
    repeat (2) tick();
    check("fwr_ack_seen",  ok, 1);
    check("fwr_latency",   d_ack_cyc[0] - req_cyc, 1);
    check("fwr_err_w_ack", err_ack[0], 1);
    check("fwr_err_once",  d_errs[0], 1);
    check("fwr_cs_quiet",  flash_low[0] + psram_low[0], 0);
    check("fwr_rdata",     b1.d_rdata_out, 8'h00);

    // Reset during bit 20 of a PSRAM read
    clear_mon();
    drive_d(1'b0, 1'b1, 24'h000555, 8'h00);
    repeat (41) tick();
    check("abort_in_shift", b1.psram_cs_out, 0);
    reset = 1'b1;
    #1;
    check("abort_cs",   {b1.flash_cs_out, b1.psram_cs_out}, 2'b11);
    check("abort_sclk", b1.sclk_out, 0);
    check("abort_busy", b1.busy_out, 0);
    b1.d_req_in = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    check("abort_no_ack", d_acks[0], 0);

    // New PSRAM read after release, request dropped mid-transfer
    clear_mon();
    miso_byte[0] = 8'hC3;
    drive_d(1'b0, 1'b1, 24'h000777, 8'h00);
    req_cyc = cyc;
    repeat (10) tick();
    b1.d_req_in = 1'b0;
    wait_ack(0, 1'b1, 200, ok);
    check("rerun_ack_seen", ok, 1);
    check("rerun_latency",  d_ack_cyc[0] - req_cyc, 81);
    check("rerun_mosi",     cap[0], 40'h03_000777_00);
    check("rerun_rdata",    b1.d_rdata_out, 8'hC3);
    check("rerun_err",      d_errs[0], 0);

    // SCLK_HALF = 3 fetch
    clear_mon();
    miso_byte[1] = 8'h96;
    b3.if_req_in = 1'b1; b3.if_addr_in = 24'h0ABCDE;
    req_cyc = cyc;
    wait_ack(1, 1'b0, 600, ok);
    b3.if_req_in = 1'b0;
    check("h3_ack_seen",  ok, 1);
    check("h3_latency",   if_ack_cyc[1] - req_cyc, 241);
    check("h3_flash_low", flash_low[1], 240);
    check("h3_sclk_per",  sclk_period[1], 6);
    check("h3_mosi",      cap[1], 40'h03_0ABCDE_00);
    check("h3_rdata",     b3.if_rdata_out, 8'h96);

    check("never_both_cs", both_low_total, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
